mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of the request and memory address.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: width of the data paths.
REQ-003 SHALL have parameter RD_LATENCY, default 2: cycles from the enable-asserted cycle to valid rd_data; legal range is 1..15.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  sole clock; all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  an access request is offered.
- req_ready  out  1  the block accepts a request this cycle.
- req_addr  in  ADDR_WIDTH  request address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  a response is available.
- rsp_ready  in  1  the consumer takes the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_we  out  1  echo of the request's req_we.
- enable  out  1  memory access strobe.
- wr_en  out  1  memory write qualifier, valid only when enable=1.
- address  out  ADDR_WIDTH  memory address.
- wr_data  out  DATA_WIDTH  memory write data.
- rd_data  in  DATA_WIDTH  memory read data.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-006 SHALL, in IDLE, drive req_ready=1; in all other states req_ready=0.
- A handshake occurs when req_valid=1 and req_ready=1.
- On a handshake, latch req_addr, req_we and req_wdata, then go to ISSUE.
REQ-007 SHALL, in ISSUE, drive enable=1 for exactly one cycle, with address, wr_data and wr_en taken from the latched request.
REQ-008 SHALL, when enable=0, drive wr_en=0 and hold address and wr_data at their last values.
REQ-009 SHALL complete a write as follows.
- ISSUE goes to RESP on the next edge.
- rsp_rdata=0 and rsp_we=1.
REQ-010 SHALL complete a read as follows.
- ISSUE goes to WAIT, loading a counter with RD_LATENCY-1.
- The counter decrements each cycle.
- When the counter is 0, sample rd_data into rsp_rdata and go to RESP.
- rd_data is therefore captured at the end of cycle T+RD_LATENCY, where T is the enable cycle.
- For RD_LATENCY=1, WAIT lasts exactly one cycle.
REQ-011 SHALL, in RESP, drive rsp_valid=1 with rsp_rdata and rsp_we held stable until rsp_ready=1; on that edge, go to IDLE.
REQ-012 SHALL accept no new request until the response handshake completes; there is no pipelining.
- Minimum read period is RD_LATENCY+3 cycles.
- Minimum write period is 3 cycles.
REQ-013 SHALL ignore changes on req_* outside the accepting IDLE cycle.
REQ-014 SHALL size the WAIT counter at 4 bits; no wrap-around is permitted because the counter is only loaded with values up to 14.
REQ-015 SHALL, under a simultaneous rsp_ready handshake and req_valid in RESP, not accept the request that cycle; it is accepted in IDLE on the following cycle.
REQ-016 SHALL handle address 2**ADDR_WIDTH-1 with no special casing.

Reset
REQ-017 SHALL, while resetn=0, asynchronously force the following.
- state = IDLE.
- enable = 0 and wr_en = 0.
- address, wr_data and rsp_rdata = 0.
- rsp_valid = 0 and rsp_we = 0.
- req_ready = 0 during reset, rising to 1 on the first edge after release.
REQ-018 SHALL, on reset asserted mid-access (ISSUE, WAIT or RESP), abandon the access with no response; the first post-reset request SHALL behave exactly as after power-up.

Verification
REQ-019 Read, RD_LATENCY=2: req addr=0x1234, we=0 accepted at cycle 0 -> enable=1, address=0x1234 at cycle 1; memory returns 0xA5 at cycle 3 -> rsp_valid=1, rsp_rdata=0xA5, rsp_we=0 at cycle 4.
REQ-020 Write: req addr=0xFFFF, we=1, wdata=0x3C -> one cycle with enable=1, wr_en=1, address=0xFFFF, wr_data=0x3C; the next cycle gives rsp_valid=1, rsp_rdata=0x00, rsp_we=1.
REQ-021 Backpressure: rsp_ready held at 0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata are stable, req_ready=0, enable=0 throughout; IDLE follows one cycle after rsp_ready=1.
REQ-022 Back-to-back: req_valid held at 1 with 3 alternating requests and rsp_ready=1 -> exactly 3 enable pulses, responses in order, no request dropped or duplicated.
REQ-023 Reset mid-WAIT: resetn=0 during WAIT -> all outputs are 0 immediately; after release a read of 0x0001 completes with correct data and no stale response appears.
REQ-024 RD_LATENCY=1 build: a read captures rd_data exactly one cycle after the enable cycle.

Source files
------------

// File: rtl/mem_master.sv
// mem_master: single-outstanding memory access master.
// Ports: clk, resetn, req_* (request in), rsp_* (response out), enable/wr_en/address/wr_data/rd_data (memory side).
module mem_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_we,
    output logic                  enable,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // WAIT runs RD_LATENCY cycles: load N-1, sample when it reaches 0.
    localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

    state_t     state;
    logic       we_q;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            cnt       <= '0;
            req_ready <= 1'b0;
            enable    <= 1'b0;
            wr_en     <= 1'b0;
            address   <= '0;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_we    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        // address/wr_data double as the request latch
                        req_ready <= 1'b0;
                        enable    <= 1'b1;
                        wr_en     <= req_we;
                        address   <= req_addr;
                        wr_data   <= req_wdata;
                        we_q      <= req_we;
                        state     <= ISSUE;
                    end else begin
                        // also raises ready on the first edge after reset
                        req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    enable <= 1'b0;
                    wr_en  <= 1'b0;
                    if (we_q) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_we    <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd_data;
                        rsp_we    <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // a req_valid seen here waits for IDLE
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: randomized + directed bench for mem_master.
// Transaction-level reference memory plus a latency-exact memory model.
module tb_mem_master;

    localparam int L0 = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rdata;
    logic        rsp_we;
    logic        enable;
    logic        wr_en;
    logic [15:0] address;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data = '0;

    logic        req_valid_1 = 1'b0;
    logic        req_ready_1;
    logic [15:0] req_addr_1 = '0;
    logic        req_we_1 = 1'b0;
    logic [7:0]  req_wdata_1 = '0;
    logic        rsp_valid_1;
    logic        rsp_ready_1 = 1'b0;
    logic [7:0]  rsp_rdata_1;
    logic        rsp_we_1;
    logic        enable_1;
    logic        wr_en_1;
    logic [15:0] address_1;
    logic [7:0]  wr_data_1;
    logic [7:0]  rd_data_1 = '0;

    int checks = 0;
    int failures = 0;
    int en_count = 0;
    int exp_en = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [int];
    int         pend = 0;
    logic [15:0] pa = '0;
    logic       hit;

    always #5 clk = ~clk;

    mem_master #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(L0)) u_dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_we(rsp_we),
        .enable(enable), .wr_en(wr_en), .address(address),
        .wr_data(wr_data), .rd_data(rd_data)
    );

    mem_master #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_addr(req_addr_1), .req_we(req_we_1), .req_wdata(req_wdata_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_we(rsp_we_1),
        .enable(enable_1), .wr_en(wr_en_1), .address(address_1),
        .wr_data(wr_data_1), .rd_data(rd_data_1)
    );

    function automatic logic [7:0] seed_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return seed_val(a);
    endfunction

    // Memory: data valid only in cycle T+L0, inverted otherwise.
    always @(negedge clk) begin
        if (!resetn) begin
            pend = 0;
            rd_data = 8'($urandom);
        end else begin
            hit = 1'b0;
            if (pend > 0) begin
                pend = pend - 1;
                hit = (pend == 0);
            end
            rd_data = hit ? mem[pa] : ~mem[pa];
            if (enable === 1'b1) begin
                en_count = en_count + 1;
                if (wr_en === 1'b1) begin
                    mem[address] = wr_data;
                end else begin
                    pa = address;
                    pend = L0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [15:0] a, input logic w,
                       input logic [7:0] d, input int bp);
        int n;
        int lat;
        logic [7:0] erd;
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = w;
        req_wdata = d;
        rsp_ready = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        check("hs_ready", 32'(req_ready), 32'd1);
        tick;
        exp_en++;
        check("iss_en", 32'(enable), 32'd1);
        check("iss_addr", 32'(address), 32'(a));
        check("iss_wren", 32'(wr_en), 32'(w));
        check("iss_rdy", 32'(req_ready), 32'd0);
        if (w) begin
            check("iss_wdata", 32'(wr_data), 32'(d));
            ref_mem[int'(a)] = d;
            erd = 8'h00;
        end else begin
            erd = ref_rd(a);
        end
        req_addr  = 16'($urandom);
        req_we    = 1'($urandom);
        req_wdata = 8'($urandom);
        lat = w ? 1 : L0 + 1;
        for (int k = 1; k < lat; k++) begin
            tick;
            check("wait_en", 32'(enable), 32'd0);
            check("wait_rv", 32'(rsp_valid), 32'd0);
        end
        tick;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", 32'(rsp_rdata), 32'(erd));
        check("rsp_we", 32'(rsp_we), 32'(w));
        check("rsp_hold_addr", 32'(address), 32'(a));
        check("rsp_wren0", 32'(wr_en), 32'd0);
        for (int b = 0; b < bp; b++) begin
            tick;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", 32'(rsp_rdata), 32'(erd));
            check("bp_rdy", 32'(req_ready), 32'd0);
            check("bp_en", 32'(enable), 32'd0);
        end
        // request offered alongside the response handshake
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        tick;
        check("idle_rv", 32'(rsp_valid), 32'd0);
        check("idle_rdy", 32'(req_ready), 32'd1);
        check("idle_en", 32'(enable), 32'd0);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] a;
        logic        w;
        for (int i = 0; i < 65536; i++) mem[i] = seed_val(16'(i));

        #2;
        check("rst_rdy", 32'(req_ready), 32'd0);
        check("rst_en", 32'(enable), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_rv", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        tick;
        tick;
        resetn = 1'b1;
        check("rel_rdy0", 32'(req_ready), 32'd0);
        tick;
        check("rel_rdy1", 32'(req_ready), 32'd1);

        txn(16'h1234, 1'b1, 8'hA5, 0);
        txn(16'h1234, 1'b0, 8'h00, 0);
        txn(16'hFFFF, 1'b1, 8'h3C, 0);
        txn(16'hFFFF, 1'b0, 8'h00, 0);
        txn(16'h0042, 1'b0, 8'h00, 5);
        txn(16'h0005, 1'b1, 8'h77, 0);
        txn(16'h0005, 1'b0, 8'h00, 0);
        txn(16'h0006, 1'b1, 8'h99, 0);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 16'hFFFF
                                            : 16'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            txn(a, w, 8'($urandom), int'($urandom_range(0, 3)));
        end

        // reset during WAIT
        req_valid = 1'b1;
        req_addr  = 16'h0002;
        req_we    = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        tick;
        exp_en++;
        req_valid = 1'b0;
        check("mw_en", 32'(enable), 32'd1);
        tick;
        #2;
        resetn = 1'b0;
        #1;
        check("mw_en0", 32'(enable), 32'd0);
        check("mw_wren0", 32'(wr_en), 32'd0);
        check("mw_addr0", 32'(address), 32'd0);
        check("mw_wd0", 32'(wr_data), 32'd0);
        check("mw_rv0", 32'(rsp_valid), 32'd0);
        check("mw_rd0", 32'(rsp_rdata), 32'd0);
        check("mw_we0", 32'(rsp_we), 32'd0);
        check("mw_rdy0", 32'(req_ready), 32'd0);
        tick;
        tick;
        resetn = 1'b1;
        tick;
        check("mw_rdy1", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick;
            check("mw_norsp", 32'(rsp_valid), 32'd0);
        end
        txn(16'h0001, 1'b0, 8'h00, 0);
        txn(16'h0001, 1'b1, 8'hE1, 1);
        txn(16'h0001, 1'b0, 8'h00, 0);

        check("en_pulses", 32'(en_count), 32'(exp_en));

        // RD_LATENCY=1 instance
        req_valid_1 = 1'b1;
        req_addr_1  = 16'h0042;
        req_we_1    = 1'b0;
        n = 0;
        while (req_ready_1 !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        check("l1_hs", 32'(req_ready_1), 32'd1);
        tick;
        req_valid_1 = 1'b0;
        rd_data_1 = 8'hEE;
        check("l1_en", 32'(enable_1), 32'd1);
        check("l1_addr", 32'(address_1), 32'h0042);
        tick;
        rd_data_1 = 8'h5C;
        check("l1_wait_en", 32'(enable_1), 32'd0);
        check("l1_wait_rv", 32'(rsp_valid_1), 32'd0);
        tick;
        rd_data_1 = 8'hEE;
        check("l1_rv", 32'(rsp_valid_1), 32'd1);
        check("l1_rdata", 32'(rsp_rdata_1), 32'h5C);
        check("l1_we", 32'(rsp_we_1), 32'd0);
        rsp_ready_1 = 1'b1;
        tick;
        rsp_ready_1 = 1'b0;
        check("l1_idle", 32'(rsp_valid_1), 32'd0);
        check("l1_rdy", 32'(req_ready_1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
